// File: rtl/shift_out_reg.sv
// Parallel-to-serial transmitter (LSB first) for the FP adder result path.
// Optional trailing even-parity bit enabled by defining SHIFT_OUT_PARITY_EN.
module shift_out_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              load_in,
  input  logic              en_in,
  output logic              output_rdy,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              done_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef SHIFT_OUT_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  // Handshake: a word is accepted on a clock edge where output_rdy=1 and
  // load_in=1; serial_out is a new bit in every cycle where serial_valid=1.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sout_q, sout_d;
  logic              svalid_q, svalid_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
`ifdef SHIFT_OUT_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    sout_d   = sout_q;
    svalid_d = 1'b0;
    done_d   = 1'b0;
    rdy_d    = rdy_q;
`ifdef SHIFT_OUT_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // rdy_q is low for the single IDLE cycle right after DONE, so a
        // load during the done_out pulse is not taken.
        rdy_d = 1'b1;
        if (rdy_q && load_in) begin
          shreg_d = parallel_in;
          count_d = '0;
          state_d = SHIFT;
          rdy_d   = 1'b0;
`ifdef SHIFT_OUT_PARITY_EN
          parity_d = ^parallel_in;
`endif
        end
      end
      SHIFT: begin
        rdy_d = 1'b0;
        if (en_in) begin
`ifdef SHIFT_OUT_PARITY_EN
          if (count_q == CNT_W'(DATA_W)) sout_d = parity_q;
          else                           sout_d = shreg_q[0];
`else
          sout_d = shreg_q[0];
`endif
          shreg_d  = shreg_q >> 1;
          svalid_d = 1'b1;
          if (count_q == LAST_CNT) state_d = DONE;
          else                     count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        rdy_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b1;
`ifdef SHIFT_OUT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
`ifdef SHIFT_OUT_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign output_rdy   = rdy_q;
  assign serial_out   = sout_q;
  assign serial_valid = svalid_q;
  assign done_out     = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_shift_out_reg.sv
// Directed bench for shift_out_reg: frame contents, en gaps, ignored loads,
// mid-frame reset, loopback receiver and (if defined) parity.
`timescale 1ns/1ps
module tb_shift_out_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
`ifdef SHIFT_OUT_PARITY_EN
  localparam int FRAME = 33;
`else
  localparam int FRAME = 32;
`endif

  logic              clk = 1'b0;
  logic              rst_n_in = 1'b1;
  logic [DATA_W-1:0] parallel_in = '0;
  logic              load_in = 1'b0;
  logic              en_in = 1'b0;
  logic              output_rdy, serial_out, serial_valid, done_out;
  logic [1:0]        state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_out_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n_in),
    .parallel_in (parallel_in),
    .load_in     (load_in),
    .en_in       (en_in),
    .output_rdy  (output_rdy),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .done_out    (done_out),
    .state_dbg   (state_dbg)
  );

  // Loopback receiver: shifts in from the top on each valid bit, LSB first.
  logic [FRAME-1:0] rx_q = '0;
  always @(posedge clk) if (serial_valid) rx_q <= {serial_out, rx_q[FRAME-1:1]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a word, clocks out one frame and checks bits, gaps, done and ready.
  task automatic send(input logic [31:0] word, input bit toggle, input int pulse_at);
    logic [FRAME-1:0] exp_f;
    logic [FRAME-1:0] got;
    logic             last;
    int               nbits;
    int               c;
    bit               early_done;
    bit               unstable;
    int               exp_done;
    exp_f = '0;
    got   = '0;
    last  = 1'b0;
    nbits = 0;
    c     = 0;
    early_done = 1'b0;
    unstable   = 1'b0;
    exp_f[31:0] = word;
`ifdef SHIFT_OUT_PARITY_EN
    exp_f[FRAME-1] = ^word;
`endif
    exp_done = toggle ? 2 * FRAME : FRAME + 1;
    chk("rdy_before_load", output_rdy, 1);
    parallel_in = word;
    load_in = 1'b1;
    en_in = 1'b1;
    tick();
    load_in = 1'b0;
    parallel_in = $urandom;
    chk("rdy_after_load", output_rdy, 0);
    chk("valid_at_load", serial_valid, 0);
    while (nbits < FRAME && c < 400) begin
      en_in = toggle ? ((c % 2) == 0) : 1'b1;
      if (pulse_at >= 0 && nbits == pulse_at) begin
        load_in = 1'b1;
        parallel_in = 32'hFFFF_FFFF;
      end else begin
        load_in = 1'b0;
      end
      tick();
      c++;
      if (done_out) early_done = 1'b1;
      if (serial_valid) begin
        got[nbits] = serial_out;
        last = serial_out;
        nbits++;
      end else if (nbits > 0 && serial_out !== last) begin
        unstable = 1'b1;
      end
    end
    chk("frame_len", nbits, FRAME);
    chk("frame_bits", got, exp_f);
    chk("no_early_done", early_done, 0);
    chk("gap_stable", unstable, 0);
    load_in = 1'b1;
    parallel_in = 32'h5555_AAAA;
    tick();
    c++;
    chk("done_pulse", done_out, 1);
    chk("done_valid", serial_valid, 0);
    chk("done_sout_hold", serial_out, last);
    chk("done_rdy", output_rdy, 0);
    chk("done_cycle", c, exp_done);
    tick();
    chk("done_clear", done_out, 0);
    chk("rdy_back", output_rdy, 1);
    chk("idle_valid", serial_valid, 0);
    load_in = 1'b0;
    tick();
    chk("load_ignored_after_done", output_rdy, 1);
  endtask

  initial begin
    #1 rst_n_in = 1'b0;
    #1;
    chk("reset_rdy", output_rdy, 1);
    chk("reset_sout", serial_out, 0);
    chk("reset_valid", serial_valid, 0);
    chk("reset_done", done_out, 0);
    chk("reset_state", state_dbg, 0);
    tick();
    tick();
    #2 rst_n_in = 1'b1;
    tick();

    send(32'h3F80_0000, 1'b0, -1);
    send(32'hA5A5_A5A5, 1'b1, -1);
    send(32'h1234_5678, 1'b0, 10);

    // Mid-frame reset after 5 bits.
    parallel_in = 32'hDEAD_BEEF;
    load_in = 1'b1;
    tick();
    load_in = 1'b0;
    en_in = 1'b1;
    repeat (5) tick();
    chk("pre_reset_valid", serial_valid, 1);
    chk("pre_reset_rdy", output_rdy, 0);
    #2 rst_n_in = 1'b0;
    #1;
    chk("abort_rdy", output_rdy, 1);
    chk("abort_sout", serial_out, 0);
    chk("abort_valid", serial_valid, 0);
    chk("abort_done", done_out, 0);
    chk("abort_state", state_dbg, 0);
    tick();
    chk("abort_no_done", done_out, 0);
    #2 rst_n_in = 1'b1;
    tick();
    chk("post_abort_done", done_out, 0);
    send(32'h0000_0001, 1'b0, -1);

    send(32'h4049_0FDB, 1'b0, -1);
    chk("loopback_word", rx_q[31:0], 32'h4049_0FDB);

`ifdef SHIFT_OUT_PARITY_EN
    send(32'h0000_0007, 1'b0, -1);
    chk("parity_bit_7", rx_q[32], 1);
    send(32'h0000_0003, 1'b1, -1);
    chk("parity_bit_3", rx_q[32], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
